// File: rtl/counter_log_pkg.sv
// Shared constants for the counter event logger: event-type codes and record layout.
package counter_log_pkg;

  // Event-type codes carried in the top two bits of every record.
  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_RCO  = 2'b01;
  localparam logic [1:0] EV_LOAD = 2'b10;
  localparam logic [1:0] EV_BOTH = 2'b11;

  localparam int unsigned DEF_TS_W = 16;

  // Field widths of one record: {ev_type, modo, q, timestamp}, MSB first.
  localparam int unsigned EV_W   = 2;
  localparam int unsigned MODO_W = 2;
  localparam int unsigned Q_W    = 4;

  // Field positions for the default timestamp width.
  localparam int unsigned TS_LSB   = 0;
  localparam int unsigned Q_MSB    = DEF_TS_W + Q_W - 1;
  localparam int unsigned MODO_MSB = Q_MSB + MODO_W;
  localparam int unsigned EV_MSB   = MODO_MSB + EV_W;

endpackage

// File: rtl/counter_event_logger_if.sv
// Valid/ready read port of the event logger FIFO.
interface counter_event_logger_if #(
  parameter int unsigned TS_W = counter_log_pkg::DEF_TS_W
);
  localparam int unsigned ENTRY_W = 8 + TS_W;

  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  // Logger side drives the head entry; reader side drives acceptance.
  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/log_fifo.sv
// Synchronous FIFO with occupancy count; storage is not reset.
module log_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok) count_d = count_q + (AW + 1)'(1);
    if (pop_ok && !push_ok) count_d = count_q - (AW + 1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/counter_event_logger.sv
// Timestamps RCO/LOAD rising edges of the 4-bit counter and queues them for a reader.
module counter_event_logger
  import counter_log_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = DEF_TS_W
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic [3:0]             Q,
  input  logic                   RCO,
  input  logic                   LOAD,
  input  logic [1:0]             MODO,
  counter_event_logger_if.master rd,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  localparam int unsigned ENTRY_W = 8 + TS_W;

  logic              rco_d_q, load_d_q;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_q, ovf_d;
  logic              rco_ev, load_ev, any_ev;
  logic [1:0]        ev_type;
  logic              full, empty, push, pop, drop;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign rco_ev  = RCO & ~rco_d_q;
  assign load_ev = LOAD & ~load_d_q;

  // Classify this cycle's edges; simultaneous edges share one record.
  always_comb begin
    ev_type = EV_NONE;
    if (rco_ev && load_ev) ev_type = EV_BOTH;
    else if (rco_ev)       ev_type = EV_RCO;
    else if (load_ev)      ev_type = EV_LOAD;
  end

  assign any_ev = (ev_type != EV_NONE);
  assign pop    = rd.rd_valid & rd.rd_ready;
  assign push   = any_ev & ENABLE & (~full | pop);
  assign drop   = any_ev & ENABLE & full & ~pop;

  // Timestamp advance and sticky overflow; a drop wins over a clear.
  always_comb begin
    ts_d  = ENABLE ? ts_q + TS_W'(1) : ts_q;
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Edge-detect delays run regardless of ENABLE so a level held across a disable logs once.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      rco_d_q  <= 1'b0;
      load_d_q <= 1'b0;
      ts_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rco_d_q  <= RCO;
      load_d_q <= LOAD;
      ts_q     <= ts_d;
      ovf_q    <= ovf_d;
    end
  end

  log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({ev_type, MODO, Q, ts_q}),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Stale storage is masked so the read bus reads zero while empty.
  assign rd.rd_valid = ~empty;
  assign rd.rd_data  = empty ? '0 : fifo_rdata;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_counter_event_logger.sv
// Directed bench for counter_event_logger with a queue-based scoreboard.
module tb_counter_event_logger;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TS_W  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] q = 4'h0;
  logic       rco = 1'b0;
  logic       load = 1'b0;
  logic [1:0] modo = 2'b00;
  logic       clr = 1'b0;
  logic [3:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Scoreboard state.
  logic [23:0] exp_q[$];
  logic [15:0] m_ts;
  logic        m_rco_d, m_load_d, m_ovf;

  counter_event_logger_if #(.TS_W(TS_W)) rd_if ();

  counter_event_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk      (clk),
    .RESET    (reset_n),
    .ENABLE   (en),
    .Q        (q),
    .RCO      (rco),
    .LOAD     (load),
    .MODO     (modo),
    .rd       (rd_if),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_ts     = '0;
    m_rco_d  = 1'b0;
    m_load_d = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Check outputs mid-cycle, advance the model over the coming edge, return 1 after the edge.
  task automatic step();
    logic [1:0]  et;
    logic [23:0] rec;
    bit          ev, full, mpop, push, drop;
    @(negedge clk);
    chk("rd_valid", 32'(rd_if.rd_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (exp_q.size() != 0) chk("rd_data", 32'(rd_if.rd_data), 32'(exp_q[0]));
    et   = {load & ~m_load_d, rco & ~m_rco_d};
    ev   = (et != 2'b00);
    full = (exp_q.size() == DEPTH);
    mpop = (exp_q.size() != 0) && rd_if.rd_ready;
    push = ev && en && (!full || mpop);
    drop = ev && en && full && !mpop;
    rec  = {et, modo, q, m_ts};
    if (mpop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(rec);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (en) m_ts = m_ts + 16'd1;
    m_rco_d  = rco;
    m_load_d = load;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rco(input logic [3:0] qv);
    q   = qv;
    rco = 1'b1;
    step();
    rco = 1'b0;
    step();
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    reset_model();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(rd_if.rd_valid), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    #3 reset_n = 1'b1;

    // Single RCO pulse at ts=5.
    en = 1'b1;
    rd_if.rd_ready = 1'b1;
    repeat (5) step();
    q = 4'hF; modo = 2'b00; rco = 1'b1;
    step();
    chk("rco_valid", 32'(rd_if.rd_valid), 32'h1);
    chk("rco_record", 32'(rd_if.rd_data), 32'h4F0005);
    rco = 1'b0;
    step();
    chk("rco_valid_1cyc", 32'(rd_if.rd_valid), 32'h0);
    chk("rco_count_0", 32'(count), 32'h0);

    // RCO and LOAD rising together.
    q = 4'h3; modo = 2'b11; rco = 1'b1; load = 1'b1;
    step();
    chk("both_head", 32'(rd_if.rd_data[23:16]), 32'hF3);
    rco = 1'b0; load = 1'b0;
    repeat (2) step();
    chk("both_single", 32'(count), 32'h0);

    // Overflow with reader stalled.
    rd_if.rd_ready = 1'b0;
    modo = 2'b01;
    for (int i = 0; i < 10; i++) pulse_rco(4'(i));
    chk("ovf_count", 32'(count), 32'h8);
    chk("ovf_set", 32'(overflow), 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'h0);
    rd_if.rd_ready = 1'b1;
    repeat (9) step();
    chk("drain_count", 32'(count), 32'h0);

    // Full with simultaneous pop and event.
    rd_if.rd_ready = 1'b0;
    modo = 2'b10;
    for (int i = 0; i < 8; i++) pulse_rco(4'(i + 4));
    chk("full_count", 32'(count), 32'h8);
    rd_if.rd_ready = 1'b1;
    q = 4'hA; rco = 1'b1;
    step();
    chk("full_pp_count", 32'(count), 32'h8);
    chk("full_pp_ovf", 32'(overflow), 32'h0);
    rco = 1'b0;
    repeat (10) step();

    // Held RCO, ENABLE dropped, LOAD edge while disabled.
    rd_if.rd_ready = 1'b0;
    q = 4'h7; modo = 2'b00; rco = 1'b1;
    repeat (2) step();
    en = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (2) step();
    rco = 1'b0;
    step();
    chk("hold_count", 32'(count), 32'h1);
    chk("hold_type", 32'(rd_if.rd_data[23:22]), 32'h1);
    pulse_rco(4'h2);
    rd_if.rd_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset with entries queued.
    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse_rco(4'(i + 1));
    chk("pre_rst_count", 32'(count), 32'h3);
    rco = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_valid", 32'(rd_if.rd_valid), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_overflow", 32'(overflow), 32'h0);
    reset_model();
    @(posedge clk);
    #4 reset_n = 1'b1;
    rd_if.rd_ready = 1'b1;
    step();
    rco = 1'b0;
    repeat (3) step();
    chk("post_rst_count", 32'(count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
